iparam_server: RTL and testbench
================================

IPARAM_SERVER -- requirements
Module: iparam_server

Interface
REQ-001 SHALL have parameter PARAM_WIDTH, default 26, the width of a parameter word and of the address bus.
REQ-002 SHALL have parameter PARAM_DEPTH, default 16, the number of table entries (power of two, at least 2).
REQ-003 SHALL have parameter CNT_WIDTH, default 8, the width of the served-request counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port param_addr_iwr2, input, PARAM_WIDTH bits: requested table address.
REQ-007 SHALL have port param_addr_valid_iwr2, input, 1 bit: the address is valid.
REQ-008 SHALL have port param_addr_ready_iwr2, output, 1 bit: the server accepts an address.
REQ-009 SHALL have port param_data_iwr2, output, PARAM_WIDTH bits: the returned parameter word.
REQ-010 SHALL have port param_data_valid_iwr2, output, 1 bit: the returned word is valid.
REQ-011 SHALL have port param_data_ready_iwr2, input, 1 bit: the requester accepts the word.
REQ-012 SHALL have port ld_we, input, 1 bit: table load write enable.
REQ-013 SHALL have port ld_addr, input, $clog2(PARAM_DEPTH) bits: table load address.
REQ-014 SHALL have port ld_data, input, PARAM_WIDTH bits: table load data.
REQ-015 SHALL have port req_count, output, CNT_WIDTH bits: number of completed responses, wrapping.
REQ-016 SHALL have port err_oor, output, 1 bit: sticky flag for an out-of-range address.

Function
REQ-017 SHALL implement FSM states IDLE, RD, RESP.
REQ-018 SHALL drive param_addr_ready_iwr2 high only in IDLE, as a registered output.
REQ-019 SHALL latch the address and go IDLE->RD on an address handshake (valid & ready).
REQ-020 SHALL, in RD, read the table entry into the data register and go to RESP on the next cycle.
REQ-021 SHALL hold param_data_valid_iwr2 high in RESP, with param_data_iwr2 stable until the handshake.
REQ-022 SHALL, on the data handshake in RESP, deassert valid, increment req_count (wrapping at 2^CNT_WIDTH) and return to IDLE; address ready is high again the following cycle.
REQ-023 SHALL give a minimum latency of 2 cycles from the address handshake edge to data valid, and a minimum of 3 cycles between successive address acceptances.
REQ-024 SHALL accept ld_we writes in any state, one per cycle, with no handshake.
REQ-025 SHALL, when a ld_we write and the RD read hit the same entry in the same cycle, return the old (pre-write) contents.
REQ-026 SHALL hold RESP indefinitely while param_data_ready_iwr2 is low, and ignore the address inputs meanwhile.
REQ-027 SHALL let param_data_ready_iwr2 be high before valid; the handshake occurs on the first cycle valid is high.

Reset
REQ-028 SHALL, on reset, force IDLE, clear param_addr_ready_iwr2 and param_data_valid_iwr2, zero param_data_iwr2, req_count and err_oor, and clear the latched address.
REQ-029 SHALL raise param_addr_ready_iwr2 on the first clock edge after reset release.
REQ-030 SHALL not reset the table contents; entries are undefined until loaded.
REQ-031 SHALL, when reset is asserted in RD or RESP, abandon the pending response; it is never presented.

Configuration
REQ-032 SHALL use macro IPARAM_SERVER_RANGE_CHECK_EN to select range checking.
REQ-033 SHALL, when IPARAM_SERVER_RANGE_CHECK_EN is defined and the address is >= PARAM_DEPTH, return all-zero data and set err_oor, which stays set until reset; the request still completes normally and counts in req_count.
REQ-034 SHALL, when IPARAM_SERVER_RANGE_CHECK_EN is undefined, use only the low $clog2(PARAM_DEPTH) address bits (wrap-around) and tie err_oor to 0.

Verification
REQ-035 SHALL cover: load entry 3 with 0x00ABCDE, request address 3 with data ready high -> data 0x00ABCDE valid 2 cycles after the handshake, req_count goes to 1.
REQ-036 SHALL cover: request address 5 with data ready held low for 10 cycles -> valid and data stable for all 10 cycles, address ready low throughout, one handshake on release.
REQ-037 SHALL cover: entry 2 = 0x1, ld_we writes 0x2 to entry 2 in the RD cycle of a request for address 2 -> response 0x1; the next request returns 0x2.
REQ-038 SHALL cover: request address 20 -> with the macro, data 0 and err_oor=1 persisting; without the macro, entry 4 is returned and err_oor=0.
REQ-039 SHALL cover: 256 back-to-back requests -> req_count wraps to 0 and each request is spaced at least 3 cycles apart.
REQ-040 SHALL cover: assert rst_n low during RESP -> valid drops immediately, address ready returns 1 cycle after release, req_count=0, and no stale response appears.

Source files
------------

// File: rtl/iparam_server.sv
// iparam_server: handshaked parameter-table server (IDLE -> RD -> RESP) with a side load port.
// Define IPARAM_SERVER_RANGE_CHECK_EN to return zero and flag err_oor for addresses >= PARAM_DEPTH.
module iparam_server #(
  parameter int PARAM_WIDTH = 26,
  parameter int PARAM_DEPTH = 16,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PARAM_WIDTH-1:0]         param_addr_iwr2,
  input  logic                           param_addr_valid_iwr2,
  output logic                           param_addr_ready_iwr2,
  output logic [PARAM_WIDTH-1:0]         param_data_iwr2,
  output logic                           param_data_valid_iwr2,
  input  logic                           param_data_ready_iwr2,
  input  logic                           ld_we,
  input  logic [$clog2(PARAM_DEPTH)-1:0] ld_addr,
  input  logic [PARAM_WIDTH-1:0]         ld_data,
  output logic [CNT_WIDTH-1:0]           req_count,
  output logic                           err_oor
);
  localparam int AW = $clog2(PARAM_DEPTH);

  typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_addr_hs;
  logic                   w_data_hs;
  logic                   r_addr_ready;
  logic                   r_data_valid;
  logic [PARAM_WIDTH-1:0] r_addr;
  logic [PARAM_WIDTH-1:0] r_data;
  logic [PARAM_WIDTH-1:0] w_rd_data;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [AW-1:0]          w_idx;
  logic [PARAM_WIDTH-1:0] r_mem [PARAM_DEPTH];

  assign w_idx = r_addr[AW-1:0];

  // Table is deliberately not reset; a same-cycle load and RD read sees the old word.
  always_ff @(posedge clk) begin
    if (ld_we) r_mem[ld_addr] <= ld_data;
  end

`ifdef IPARAM_SERVER_RANGE_CHECK_EN
  logic w_oor;
  logic r_err;

  assign w_oor     = (r_addr >= PARAM_WIDTH'(PARAM_DEPTH));
  assign w_rd_data = w_oor ? '0 : r_mem[w_idx];
  assign err_oor   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_err <= 1'b0;
    else if ((r_state == RD) && w_oor) r_err <= 1'b1;
  end
`else
  logic w_unused_addr_hi;

  assign w_unused_addr_hi = ^r_addr[PARAM_WIDTH-1:AW];
  assign w_rd_data        = r_mem[w_idx];
  assign err_oor          = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_addr_hs = 1'b0;
    w_data_hs = 1'b0;
    case (r_state)
      IDLE: begin
        if (param_addr_valid_iwr2 && r_addr_ready) begin
          w_addr_hs = 1'b1;
          w_next    = RD;
        end
      end
      RD:   w_next = RESP;
      RESP: begin
        if (r_data_valid && param_data_ready_iwr2) begin
          w_data_hs = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_addr_ready <= 1'b0;
      r_data_valid <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_next;
      r_addr_ready <= (w_next == IDLE);
      r_data_valid <= (w_next == RESP);
      if (w_addr_hs)       r_addr <= param_addr_iwr2;
      if (r_state == RD)   r_data <= w_rd_data;
      if (w_data_hs)       r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign param_addr_ready_iwr2 = r_addr_ready;
  assign param_data_valid_iwr2 = r_data_valid;
  assign param_data_iwr2       = r_data;
  assign req_count             = r_cnt;
endmodule

// File: tb/tb_iparam_server.sv
// Randomized self-checking bench for iparam_server against a table/counter reference model.
module tb_iparam_server;
  localparam int PW = 26;
  localparam int PD = 16;
  localparam int CW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] addr = '0;
  logic          addr_valid = 1'b0;
  logic          addr_ready;
  logic [PW-1:0] data;
  logic          data_valid;
  logic          data_ready = 1'b0;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [PW-1:0] ld_data = '0;
  logic [CW-1:0] req_count;
  logic          err_oor;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [PW-1:0] model [PD];
  int            model_cnt = 0;
  bit            model_err = 1'b0;

  iparam_server #(.PARAM_WIDTH(PW), .PARAM_DEPTH(PD), .CNT_WIDTH(CW)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .param_addr_iwr2       (addr),
    .param_addr_valid_iwr2 (addr_valid),
    .param_addr_ready_iwr2 (addr_ready),
    .param_data_iwr2       (data),
    .param_data_valid_iwr2 (data_valid),
    .param_data_ready_iwr2 (data_ready),
    .ld_we                 (ld_we),
    .ld_addr               (ld_addr),
    .ld_data               (ld_data),
    .req_count             (req_count),
    .err_oor               (err_oor)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] exp_data(input logic [PW-1:0] a);
`ifdef IPARAM_SERVER_RANGE_CHECK_EN
    if (a >= PW'(PD)) return '0;
`endif
    return model[a % PD];
  endfunction

  function automatic bit exp_err(input logic [PW-1:0] a, input bit prev);
`ifdef IPARAM_SERVER_RANGE_CHECK_EN
    return prev || (a >= PW'(PD));
`else
    return prev && (a == a) && 1'b0;
`endif
  endfunction

  task automatic load(input int a, input logic [PW-1:0] d);
    @(posedge clk); #1;
    ld_we = 1'b1; ld_addr = AW'(a); ld_data = d;
    model[a] = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; addr_valid = 1'b0; ld_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    model_cnt = 0; model_err = 1'b0;
  endtask

  // Issues one request; data_ready must already be high for it to complete.
  task automatic req(input logic [PW-1:0] a, output logic [PW-1:0] d, output int lat, output bit ok);
    int n;
    ok = 1'b1; lat = 0; d = '0;
    @(posedge clk); #1;
    addr = a; addr_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!addr_ready && n < 20) begin @(negedge clk); n++; end
    if (!addr_ready) begin addr_valid = 1'b0; ok = 1'b0; return; end
    @(posedge clk); #1;
    addr_valid = 1'b0; addr = PW'($urandom);
    do begin @(negedge clk); lat++; end while (!(data_valid && data_ready) && lat < 50);
    if (!(data_valid && data_ready)) begin ok = 1'b0; return; end
    d = data;
    @(posedge clk); #1;
    model_cnt = (model_cnt + 1) % 256;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({addr_ready, data_valid, err_oor} !== 3'b000 || data !== '0 || req_count !== '0) begin
      failures++;
      $display("FAIL reset_state: got rdy=%b vld=%b err=%b data=%h cnt=%0d want 0,0,0,0,0",
               addr_ready, data_valid, err_oor, data, req_count);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (addr_ready !== 1'b0) begin failures++; $display("FAIL reset_release_early: got rdy=%b want 0", addr_ready); end
    @(posedge clk); #1;
    checks++;
    if (addr_ready !== 1'b1) begin failures++; $display("FAIL reset_first_edge: got rdy=%b want 1", addr_ready); end
    model_cnt = 0; model_err = 1'b0;
  endtask

  task automatic test_basic();
    logic [PW-1:0] d; int lat; bit ok;
    data_ready = 1'b1;
    load(3, 26'h00ABCDE);
    req(26'd3, d, lat, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout: got ok=%b want 1", ok); end
    checks++;
    if (d !== 26'h00ABCDE) begin failures++; $display("FAIL basic_data: got %h want %h", d, 26'h00ABCDE); end
    checks++;
    if (lat != 2) begin failures++; $display("FAIL basic_latency: got %0d want 2", lat); end
    checks++;
    if (req_count !== CW'(model_cnt) || model_cnt != 1) begin
      failures++; $display("FAIL basic_count: got %0d want 1", req_count);
    end
    checks++;
    if (addr_ready !== 1'b1 || data_valid !== 1'b0) begin
      failures++; $display("FAIL basic_return_idle: got rdy=%b vld=%b want 1,0", addr_ready, data_valid);
    end
  endtask

  task automatic test_stall();
    logic [PW-1:0] v; int n; bit stable;
    v = PW'($urandom);
    load(5, v);
    data_ready = 1'b0;
    @(posedge clk); #1;
    addr = 26'd5; addr_valid = 1'b1;
    n = 0; @(negedge clk);
    while (!addr_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    addr = 26'd7;
    n = 0; @(negedge clk);
    while (!data_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!data_valid) begin failures++; $display("FAIL stall_valid_timeout: got vld=%b want 1", data_valid); end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (data_valid !== 1'b1 || data !== v || addr_ready !== 1'b0) stable = 1'b0;
      if (i < 9) @(negedge clk);
    end
    checks++;
    if (!stable) begin failures++; $display("FAIL stall_hold: got vld=%b data=%h rdy=%b want 1,%h,0", data_valid, data, addr_ready, v); end
    @(posedge clk); #1;
    addr_valid = 1'b0; data_ready = 1'b1;
    @(posedge clk); #1;
    model_cnt = (model_cnt + 1) % 256;
    checks++;
    if (data_valid !== 1'b0 || addr_ready !== 1'b1 || req_count !== CW'(model_cnt)) begin
      failures++;
      $display("FAIL stall_release: got vld=%b rdy=%b cnt=%0d want 0,1,%0d", data_valid, addr_ready, req_count, model_cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (data_valid !== 1'b0 || req_count !== CW'(model_cnt)) begin
      failures++; $display("FAIL stall_single_hs: got vld=%b cnt=%0d want 0,%0d", data_valid, req_count, model_cnt);
    end
  endtask

  task automatic test_collision();
    logic [PW-1:0] d; int lat; bit ok; int n;
    load(2, 26'h1);
    data_ready = 1'b1;
    @(posedge clk); #1;
    addr = 26'd2; addr_valid = 1'b1;
    n = 0; @(negedge clk);
    while (!addr_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    addr_valid = 1'b0; ld_we = 1'b1; ld_addr = 4'd2; ld_data = 26'h2;
    @(posedge clk); #1;
    ld_we = 1'b0; model[2] = 26'h2;
    n = 0; @(negedge clk);
    while (!(data_valid && data_ready) && n < 20) begin @(negedge clk); n++; end
    d = data;
    @(posedge clk); #1;
    model_cnt = (model_cnt + 1) % 256;
    checks++;
    if (d !== 26'h1) begin failures++; $display("FAIL collision_old: got %h want %h", d, 26'h1); end
    req(26'd2, d, lat, ok);
    checks++;
    if (!ok || d !== 26'h2) begin failures++; $display("FAIL collision_new: got %h ok=%b want %h", d, ok, 26'h2); end
  endtask

  task automatic test_oor();
    logic [PW-1:0] v; logic [PW-1:0] d; logic [PW-1:0] e; int lat; bit ok;
    v = PW'($urandom);
    load(4, v);
    data_ready = 1'b1;
    e = exp_data(26'd20);
    req(26'd20, d, lat, ok);
    model_err = exp_err(26'd20, model_err);
    checks++;
    if (!ok || d !== e) begin failures++; $display("FAIL oor_data: got %h ok=%b want %h", d, ok, e); end
    checks++;
    if (err_oor !== model_err) begin failures++; $display("FAIL oor_flag: got %b want %b", err_oor, model_err); end
    checks++;
    if (req_count !== CW'(model_cnt)) begin failures++; $display("FAIL oor_count: got %0d want %0d", req_count, model_cnt); end
    req(26'd4, d, lat, ok);
    checks++;
    if (!ok || d !== v || err_oor !== model_err) begin
      failures++; $display("FAIL oor_after: got %h err=%b want %h err=%b", d, err_oor, v, model_err);
    end
  endtask

  task automatic test_random();
    logic [PW-1:0] a; logic [PW-1:0] d; logic [PW-1:0] e; int lat; bit ok;
    for (int i = 0; i < PD; i++) load(i, PW'($urandom));
    data_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (($urandom % 4) == 0) load(int'($urandom_range(0, PD-1)), PW'($urandom));
      a = PW'($urandom_range(0, 2*PD-1));
      e = exp_data(a);
      req(a, d, lat, ok);
      model_err = exp_err(a, model_err);
      checks++;
      if (!ok || d !== e || lat != 2) begin
        failures++; $display("FAIL random_req: addr=%0d got %h lat=%0d want %h lat=2", a, d, lat, e);
      end
      checks++;
      if (req_count !== CW'(model_cnt) || err_oor !== model_err) begin
        failures++; $display("FAIL random_status: got cnt=%0d err=%b want %0d,%b", req_count, err_oor, model_cnt, model_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] q [$];
    logic [PW-1:0] a;
    int acc, rsp, last, it;
    apply_reset();
    acc = 0; rsp = 0; last = -1; it = 0;
    a = PW'($urandom_range(0, PD-1));
    @(posedge clk); #1;
    addr = a; addr_valid = 1'b1; data_ready = 1'b1;
    while ((acc < 256 || rsp < 256) && it < 3000) begin
      @(negedge clk); it++;
      if (addr_valid && addr_ready) begin
        q.push_back(exp_data(a));
        checks++;
        if (req_count !== CW'(rsp)) begin failures++; $display("FAIL b2b_count: got %0d want %0d", req_count, rsp % 256); end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 3) begin failures++; $display("FAIL b2b_spacing: got %0d want 3", cyc - last); end
        end
        last = cyc; acc++;
        @(posedge clk); #1;
        if (acc == 256) addr_valid = 1'b0;
        else begin a = PW'($urandom_range(0, PD-1)); addr = a; end
      end else if (data_valid && data_ready) begin
        checks++;
        if (q.size() == 0) begin failures++; $display("FAIL b2b_extra_resp: got %h want none", data); end
        else begin
          if (data !== q[0]) begin failures++; $display("FAIL b2b_data: got %h want %h", data, q[0]); end
          void'(q.pop_front());
        end
        rsp++;
      end
    end
    checks++;
    if (acc != 256 || rsp != 256) begin failures++; $display("FAIL b2b_timeout: got acc=%0d rsp=%0d want 256,256", acc, rsp); end
    @(posedge clk); #1;
    model_cnt = (model_cnt + rsp) % 256;
    checks++;
    if (req_count !== CW'(model_cnt) || model_cnt != 0) begin
      failures++; $display("FAIL b2b_wrap: got %0d want 0", req_count);
    end
  endtask

  task automatic test_reset_in_resp();
    logic [PW-1:0] v; int n; bit stale;
    v = PW'($urandom) | 26'h1;
    load(6, v);
    data_ready = 1'b0;
    @(posedge clk); #1;
    addr = 26'd6; addr_valid = 1'b1;
    n = 0; @(negedge clk);
    while (!addr_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    addr_valid = 1'b0;
    n = 0; @(negedge clk);
    while (!data_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (data_valid !== 1'b1) begin failures++; $display("FAIL rst_resp_setup: got vld=%b want 1", data_valid); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_cnt = 0; model_err = 1'b0;
    checks++;
    if (data_valid !== 1'b0 || addr_ready !== 1'b0 || req_count !== '0 || data !== '0 || err_oor !== 1'b0) begin
      failures++;
      $display("FAIL rst_resp_async: got vld=%b rdy=%b cnt=%0d data=%h err=%b want 0,0,0,0,0",
               data_valid, addr_ready, req_count, data, err_oor);
    end
    data_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (addr_ready !== 1'b1) begin failures++; $display("FAIL rst_resp_ready: got %b want 1", addr_ready); end
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (data_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale || req_count !== CW'(model_cnt)) begin
      failures++; $display("FAIL rst_resp_stale: got stale=%b cnt=%0d want 0,%0d", stale, req_count, model_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_collision();
    test_oor();
    test_random();
    test_back_to_back();
    test_reset_in_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got time=%0t want completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
